// File: rtl/control_unit_seq_if.sv
// Bundles the control unit's run/instruction inputs and its datapath enables.
// "master" is the control unit side, "slave" is the datapath that supplies IR and g_nz.
interface control_unit_seq_if #(
    parameter int NUM_REGS = 8,
    parameter int RSEL_W   = 3,
    parameter int IR_W     = 3 + 2 * RSEL_W
);
    logic                run;
    logic [IR_W-1:0]     IR;
    logic                g_nz;
    logic                IRin;
    logic                DINout;
    logic [NUM_REGS-1:0] Rout;
    logic [NUM_REGS-1:0] Rin;
    logic                Ain;
    logic                Gin;
    logic                Gout;
    logic [1:0]          alu_op;
    logic                done;
    logic                busy;
    logic [1:0]          step;

    modport master (
        input  run, IR, g_nz,
        output IRin, DINout, Rout, Rin, Ain, Gin, Gout, alu_op, done, busy, step
    );

    modport slave (
        output run, IR, g_nz,
        input  IRin, DINout, Rout, Rin, Ain, Gin, Gout, alu_op, done, busy, step
    );
endinterface

// File: rtl/control_unit_seq.sv
// Self-sequencing control unit: owns the T0..T3 step counter and decodes IR into
// register-file, A/G, bus-mux and IR-load enables for the basic CPU datapath.
module control_unit_seq #(
    parameter int NUM_REGS = 8,
    parameter int RSEL_W   = 3,
    parameter int IR_W     = 3 + 2 * RSEL_W
) (
    input logic             clock,
    input logic             resetn,
    control_unit_seq_if.master bus
);
    typedef enum logic [1:0] {
        T0 = 2'b00,
        T1 = 2'b01,
        T2 = 2'b10,
        T3 = 2'b11
    } step_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_MV   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVI  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    step_t               state, next_state;
    logic [2:0]          opcode;
    logic [RSEL_W-1:0]   rx, ry;
    logic [NUM_REGS-1:0] rx_hot, ry_hot;
    logic                is_alu;

    logic                irin, dinout, ain, gin, gout, done;
    logic [NUM_REGS-1:0] rout, rin;
    logic [1:0]          alu_op;

    // Indices at or above NUM_REGS match no bit, so out-of-range selects drive nothing.
    function automatic logic [NUM_REGS-1:0] decode_reg(input logic [RSEL_W-1:0] idx);
        logic [NUM_REGS-1:0] hot;
        hot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(idx) == i) hot[i] = 1'b1;
        end
        return hot;
    endfunction

    assign opcode = bus.IR[IR_W-1 -: 3];
    assign rx     = bus.IR[2*RSEL_W-1 -: RSEL_W];
    assign ry     = bus.IR[RSEL_W-1:0];
    assign rx_hot = decode_reg(rx);
    assign ry_hot = decode_reg(ry);
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= T0;
        else         state <= next_state;
    end

    always_comb begin
        irin       = 1'b0;
        dinout     = 1'b0;
        rout       = '0;
        rin        = '0;
        ain        = 1'b0;
        gin        = 1'b0;
        gout       = 1'b0;
        alu_op     = 2'b00;
        done       = 1'b0;
        next_state = state;

        case (state)
            T0: begin
                if (bus.run) irin = 1'b1;
            end
            T1: begin
                case (opcode)
                    OP_NOP, OP_RSV: done = 1'b1;
                    OP_MV: begin
                        rout = ry_hot;
                        rin  = rx_hot;
                        done = 1'b1;
                    end
                    OP_MVI: begin
                        dinout = 1'b1;
                        rin    = rx_hot;
                        done   = 1'b1;
                    end
                    OP_MVNZ: begin
                        if (bus.g_nz) begin
                            rout = ry_hot;
                            rin  = rx_hot;
                        end
                        done = 1'b1;
                    end
                    default: begin
                        rout = rx_hot;
                        ain  = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (is_alu) begin
                    rout = ry_hot;
                    gin  = 1'b1;
                    case (opcode)
                        OP_ADD:  alu_op = 2'b01;
                        OP_SUB:  alu_op = 2'b10;
                        OP_AND:  alu_op = 2'b11;
                        default: alu_op = 2'b00;
                    endcase
                end
            end
            T3: begin
                if (is_alu) begin
                    gout = 1'b1;
                    rin  = rx_hot;
                    done = 1'b1;
                end
            end
            default: ;
        endcase

        // run only matters in T0; once started an instruction always runs to done.
        if (done)             next_state = T0;
        else if (state == T0) next_state = bus.run ? T1 : T0;
        else                  next_state = step_t'(state + 2'd1);
    end

    // Holding reset forces every output low, including a fetch requested by run.
    assign bus.IRin   = resetn & irin;
    assign bus.DINout = resetn & dinout;
    assign bus.Rout   = resetn ? rout : '0;
    assign bus.Rin    = resetn ? rin  : '0;
    assign bus.Ain    = resetn & ain;
    assign bus.Gin    = resetn & gin;
    assign bus.Gout   = resetn & gout;
    assign bus.alu_op = resetn ? alu_op : 2'b00;
    assign bus.done   = resetn & done;
    assign bus.busy   = resetn & (state != T0);
    assign bus.step   = state;
endmodule

// File: tb/tb_control_unit_seq.sv
// Self-checking bench for control_unit_seq: directed test-plan cases with literal
// expectations, then randomized instruction streams checked against a sequence model.
module tb_control_unit_seq;
    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    control_unit_seq_if #(.NUM_REGS(8), .RSEL_W(3), .IR_W(9)) cu ();
    control_unit_seq_if #(.NUM_REGS(6), .RSEL_W(3), .IR_W(9)) cu6 ();

    control_unit_seq #(.NUM_REGS(8), .RSEL_W(3), .IR_W(9)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (cu)
    );

    control_unit_seq #(.NUM_REGS(6), .RSEL_W(3), .IR_W(9)) dut6 (
        .clock  (clock),
        .resetn (resetn),
        .bus    (cu6)
    );

    typedef struct {
        logic       irin;
        logic       dinout;
        logic [7:0] rout;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [1:0] alu;
        logic       done;
        logic       busy;
        logic [1:0] step;
    } rec_t;

    int   testsRun    = 0;
    int   testsFailed = 0;
    rec_t expQ[$];
    rec_t expCur;
    bit   expValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] regHot(input int r);
        return (r < 8) ? 8'(1 << r) : 8'h00;
    endfunction

    // Whole-instruction model: the fetch cycle followed by the step list of the opcode.
    function automatic void buildSeq(input int op, input int rx, input int ry, input bit gnz);
        rec_t r;
        r = '{default: 0};
        r.irin = 1'b1;
        expQ.push_back(r);
        if (op == 2 || op == 3 || op == 6) begin
            r = '{default: 0};
            r.step = 2'd1; r.busy = 1'b1; r.rout = regHot(rx); r.ain = 1'b1;
            expQ.push_back(r);
            r = '{default: 0};
            r.step = 2'd2; r.busy = 1'b1; r.rout = regHot(ry); r.gin = 1'b1;
            r.alu = (op == 2) ? 2'd1 : (op == 3) ? 2'd2 : 2'd3;
            expQ.push_back(r);
            r = '{default: 0};
            r.step = 2'd3; r.busy = 1'b1; r.gout = 1'b1; r.rin = regHot(rx); r.done = 1'b1;
            expQ.push_back(r);
        end else begin
            r = '{default: 0};
            r.step = 2'd1; r.busy = 1'b1; r.done = 1'b1;
            if (op == 1 || (op == 5 && gnz)) begin
                r.rout = regHot(ry);
                r.rin  = regHot(rx);
            end else if (op == 4) begin
                r.dinout = 1'b1;
                r.rin    = regHot(rx);
            end
            expQ.push_back(r);
        end
    endfunction

    always begin
        @(negedge clock);
        #2;
        if (expValid) begin
            checkOutput("m_irin",   32'(cu.IRin),   32'(expCur.irin));
            checkOutput("m_dinout", 32'(cu.DINout), 32'(expCur.dinout));
            checkOutput("m_rout",   32'(cu.Rout),   32'(expCur.rout));
            checkOutput("m_rin",    32'(cu.Rin),    32'(expCur.rin));
            checkOutput("m_ain",    32'(cu.Ain),    32'(expCur.ain));
            checkOutput("m_gin",    32'(cu.Gin),    32'(expCur.gin));
            checkOutput("m_gout",   32'(cu.Gout),   32'(expCur.gout));
            checkOutput("m_alu_op", 32'(cu.alu_op), 32'(expCur.alu));
            checkOutput("m_done",   32'(cu.done),   32'(expCur.done));
            checkOutput("m_busy",   32'(cu.busy),   32'(expCur.busy));
            checkOutput("m_step",   32'(cu.step),   32'(expCur.step));
        end
    end

    task automatic drive(input logic r, input logic [8:0] ir, input logic g);
        @(negedge clock);
        #1;
        cu.run  = r;
        cu.IR   = ir;
        cu.g_nz = g;
    endtask

    task automatic applyStimulus(input int nInstr);
        int       op, rx, ry, idle;
        bit       gnz;
        logic [8:0] ir;
        for (int k = 0; k < nInstr; k++) begin
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                drive(1'b0, 9'($urandom), 1'($urandom));
                expCur   = '{default: 0};
                expValid = 1'b1;
            end
            op  = $urandom_range(0, 7);
            rx  = $urandom_range(0, 7);
            ry  = $urandom_range(0, 7);
            gnz = 1'($urandom);
            ir  = {3'(op), 3'(rx), 3'(ry)};
            expQ.delete();
            buildSeq(op, rx, ry, gnz);
            for (int i = 0; i < expQ.size(); i++) begin
                drive((i == 0) ? 1'b1 : 1'($urandom), ir, gnz);
                expCur   = expQ[i];
                expValid = 1'b1;
            end
        end
        drive(1'b0, 9'd0, 1'b0);
        expCur = '{default: 0};
        @(negedge clock);
        expValid = 1'b0;
    endtask

    initial begin
        resetn   = 1'b0;
        cu.run   = 1'b1;
        cu.IR    = 9'b001_010_101;
        cu.g_nz  = 1'b0;
        cu6.run  = 1'b0;
        cu6.IR   = 9'd0;
        cu6.g_nz = 1'b0;
        #3;
        checkOutput("rst_irin", 32'(cu.IRin), 32'd0);
        checkOutput("rst_step", 32'(cu.step), 32'd0);
        checkOutput("rst_busy", 32'(cu.busy), 32'd0);
        @(negedge clock);
        cu.run = 1'b0;
        resetn = 1'b1;

        // MV R2,R5
        drive(1'b1, 9'b001_010_101, 1'b0); #1;
        checkOutput("mv_t0_irin", 32'(cu.IRin), 32'd1);
        drive(1'b0, 9'b001_010_101, 1'b0); #1;
        checkOutput("mv_t1_rout", 32'(cu.Rout), 32'h20);
        checkOutput("mv_t1_rin",  32'(cu.Rin),  32'h04);
        checkOutput("mv_t1_done", 32'(cu.done), 32'd1);
        drive(1'b0, 9'b001_010_101, 1'b0); #1;
        checkOutput("mv_ret_step", 32'(cu.step), 32'd0);
        checkOutput("mv_ret_busy", 32'(cu.busy), 32'd0);

        // ADD R1,R3
        drive(1'b1, 9'b010_001_011, 1'b0);
        drive(1'b0, 9'b010_001_011, 1'b0); #1;
        checkOutput("add_t1_rout", 32'(cu.Rout), 32'h02);
        checkOutput("add_t1_ain",  32'(cu.Ain),  32'd1);
        drive(1'b0, 9'b010_001_011, 1'b0); #1;
        checkOutput("add_t2_rout", 32'(cu.Rout),   32'h08);
        checkOutput("add_t2_gin",  32'(cu.Gin),    32'd1);
        checkOutput("add_t2_alu",  32'(cu.alu_op), 32'd1);
        drive(1'b0, 9'b010_001_011, 1'b0); #1;
        checkOutput("add_t3_gout", 32'(cu.Gout), 32'd1);
        checkOutput("add_t3_rin",  32'(cu.Rin),  32'h02);
        checkOutput("add_t3_done", 32'(cu.done), 32'd1);

        // AND R1,R3 straight after ADD
        drive(1'b1, 9'b110_001_011, 1'b0); #1;
        checkOutput("and_t0_irin", 32'(cu.IRin), 32'd1);
        drive(1'b0, 9'b110_001_011, 1'b0);
        drive(1'b0, 9'b110_001_011, 1'b0); #1;
        checkOutput("and_t2_alu", 32'(cu.alu_op), 32'd3);
        drive(1'b0, 9'b110_001_011, 1'b0); #1;
        checkOutput("and_t3_done", 32'(cu.done), 32'd1);

        // MVNZ R4,R0 with g_nz low then high
        drive(1'b1, 9'b101_100_000, 1'b0);
        drive(1'b0, 9'b101_100_000, 1'b0); #1;
        checkOutput("mvnz0_rout", 32'(cu.Rout), 32'h00);
        checkOutput("mvnz0_rin",  32'(cu.Rin),  32'h00);
        checkOutput("mvnz0_done", 32'(cu.done), 32'd1);
        drive(1'b1, 9'b101_100_000, 1'b1);
        drive(1'b0, 9'b101_100_000, 1'b1); #1;
        checkOutput("mvnz1_rout", 32'(cu.Rout), 32'h01);
        checkOutput("mvnz1_rin",  32'(cu.Rin),  32'h10);
        checkOutput("mvnz1_done", 32'(cu.done), 32'd1);

        // SUB with run pulsed only in T0
        drive(1'b1, 9'b011_001_011, 1'b0);
        drive(1'b0, 9'b011_001_011, 1'b0); #1;
        checkOutput("sub_t1_step", 32'(cu.step), 32'd1);
        drive(1'b0, 9'b011_001_011, 1'b0); #1;
        checkOutput("sub_t2_alu", 32'(cu.alu_op), 32'd2);
        drive(1'b0, 9'b011_001_011, 1'b0); #1;
        checkOutput("sub_t3_done", 32'(cu.done), 32'd1);
        drive(1'b0, 9'b011_001_011, 1'b0); #1;
        checkOutput("sub_hold_step", 32'(cu.step), 32'd0);
        drive(1'b0, 9'b011_001_011, 1'b0); #1;
        checkOutput("sub_hold_busy", 32'(cu.busy), 32'd0);

        // Asynchronous reset in the middle of ADD's T2
        drive(1'b1, 9'b010_001_011, 1'b0);
        drive(1'b0, 9'b010_001_011, 1'b0);
        drive(1'b0, 9'b010_001_011, 1'b0); #1;
        checkOutput("ar_pre_step", 32'(cu.step), 32'd2);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("ar_step", 32'(cu.step), 32'd0);
        checkOutput("ar_outs", 32'({cu.Rout, cu.Gin, cu.alu_op, cu.busy}), 32'd0);
        cu.run = 1'b1;
        #1;
        checkOutput("ar_irin_run", 32'(cu.IRin), 32'd0);
        @(negedge clock);
        cu.run = 1'b0;
        resetn = 1'b1;
        drive(1'b0, 9'b010_001_011, 1'b0); #1;
        checkOutput("ar_rel_irin", 32'(cu.IRin), 32'd0);
        checkOutput("ar_rel_busy", 32'(cu.busy), 32'd0);

        // Six-register instance: out-of-range Rx, then reserved opcode
        @(negedge clock); #1;
        cu6.run = 1'b1; cu6.IR = 9'b001_111_001;
        @(negedge clock); #1;
        cu6.run = 1'b0;
        #1;
        checkOutput("r6_mv_rout", 32'(cu6.Rout), 32'b000010);
        checkOutput("r6_mv_rin",  32'(cu6.Rin),  32'd0);
        checkOutput("r6_mv_done", 32'(cu6.done), 32'd1);
        @(negedge clock); #1;
        cu6.run = 1'b1; cu6.IR = 9'b111_010_011;
        @(negedge clock); #1;
        cu6.run = 1'b0;
        #1;
        checkOutput("r6_rsv_done", 32'(cu6.done), 32'd1);
        checkOutput("r6_rsv_outs", 32'({cu6.IRin, cu6.DINout, cu6.Rout, cu6.Rin, cu6.Ain,
                                       cu6.Gin, cu6.Gout, cu6.alu_op}), 32'd0);

        applyStimulus(60);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
